// File: rtl/el2_lsu_stbuf_q.sv
// ---------------------------------------------------------------------------
// el2_lsu_stbuf_q
//
// Small circular store queue between LSU r-stage commit and the DCCM write
// port. Committed stores are enqueued at wr_ptr and drained oldest-first from
// rd_ptr. Entry payloads (addr/data/byteen) live on the gated clock
// lsu_stbuf_c1_clk and are never reset. Pointers, valids, count and the
// overflow pulse live on clk and are cleared by the asynchronous active-low
// reset rst_l.
//
// Optional feature macro: RV_STBUF_FWD_EN
//   Defined   : per-byte store-to-load forwarding against lsu_addr_m, newest
//               matching valid entry wins per lane.
//   Undefined : forwarding outputs tied to 0, no comparators built.
//
// Parameters:
//   DEPTH   number of entries (power of 2, >= 2)
//   ADDR_W  DCCM byte-address width
//   PTR_W   derived pointer width, $clog2(DEPTH)
//
// Ports:
//   clk, rst_l            core clock, async active-low reset
//   lsu_stbuf_c1_clk      gated clock for entry payload storage
//   dec_tlu_force_halt    discard every queued entry on the next clk edge
//   ldst_stbuf_reqvld_r   committed store allocate request
//   lsu_addr_r/store_data_r/lsu_byteen_r  store payload
//   stbuf_ack_any         DCCM accepted the head entry this cycle
//   lsu_addr_m            load address for forwarding lookup
//   stbuf_reqvld_any      head entry valid, drain requested
//   stbuf_addr_any/stbuf_data_any/stbuf_byteen_any  head payload
//   lsu_stbuf_empty_any   no valid entries
//   lsu_stbuf_full_any    count == DEPTH
//   stbuf_numvld_any      valid-entry count
//   stbuf_overflow        one-cycle pulse, the cycle after an allocate was
//                         dropped because the queue was full without ack
//   stbuf_fwdbyteen_m     forwarding byte-lane hits
//   stbuf_fwddata_m       forwarding data
// ---------------------------------------------------------------------------
module el2_lsu_stbuf_q #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              lsu_stbuf_c1_clk,
  input  logic              dec_tlu_force_halt,
  input  logic              ldst_stbuf_reqvld_r,
  input  logic [ADDR_W-1:0] lsu_addr_r,
  input  logic [31:0]       store_data_r,
  input  logic [3:0]        lsu_byteen_r,
  input  logic              stbuf_ack_any,
  input  logic [ADDR_W-1:0] lsu_addr_m,
  output logic              stbuf_reqvld_any,
  output logic [ADDR_W-1:0] stbuf_addr_any,
  output logic [31:0]       stbuf_data_any,
  output logic [3:0]        stbuf_byteen_any,
  output logic              lsu_stbuf_empty_any,
  output logic              lsu_stbuf_full_any,
  output logic [PTR_W:0]    stbuf_numvld_any,
  output logic              stbuf_overflow,
  output logic [3:0]        stbuf_fwdbyteen_m,
  output logic [31:0]       stbuf_fwddata_m
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ADDR_W-1:0] addr_q   [DEPTH];
  logic [31:0]       data_q   [DEPTH];
  logic [3:0]        byteen_q [DEPTH];

  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              overflow_q;

  logic              full;
  logic              ack_eff;
  logic              accept;
  logic              drop;

  // Allocation and drain qualifiers. An ack only counts when the head is
  // actually valid, so a stray ack on an empty queue is harmless. A full
  // queue may still accept when the head drains in the same cycle, because
  // the freed slot is exactly the one wr_ptr points at.
  assign full    = (count == FULL_CNT);
  assign ack_eff = stbuf_ack_any & valid_q[rd_ptr];
  assign accept  = ldst_stbuf_reqvld_r & (~full | stbuf_ack_any) & ~dec_tlu_force_halt;
  assign drop    = ldst_stbuf_reqvld_r & full & ~stbuf_ack_any & ~dec_tlu_force_halt;

  // Payload storage on the gated clock. No reset: the valid bits decide
  // whether a slot means anything. The upstream enable is guaranteed high on
  // every accept cycle, so a write is never lost to gating.
  always_ff @(posedge lsu_stbuf_c1_clk) begin
    if (accept) begin
      addr_q[wr_ptr]   <= lsu_addr_r;
      data_q[wr_ptr]   <= store_data_r;
      byteen_q[wr_ptr] <= lsu_byteen_r;
    end
  end

  // Control state on the core clock. Force-halt wipes everything and beats
  // any same-cycle allocate or ack. Otherwise the head is retired first and
  // the new entry marked valid second, so when full-with-ack makes both
  // pointers hit the same slot, the fresh valid bit survives.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else if (dec_tlu_force_halt) begin
      valid_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= drop;
      if (ack_eff) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_ONE;
      end
      if (accept) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      case ({accept, ack_eff})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Head and status outputs come straight from registered state, so none of
  // them has a combinational path from the request inputs.
  assign stbuf_reqvld_any    = valid_q[rd_ptr];
  assign stbuf_addr_any      = addr_q[rd_ptr];
  assign stbuf_data_any      = data_q[rd_ptr];
  assign stbuf_byteen_any    = byteen_q[rd_ptr];
  assign lsu_stbuf_empty_any = (count == '0);
  assign lsu_stbuf_full_any  = full;
  assign stbuf_numvld_any    = count;
  assign stbuf_overflow      = overflow_q;

`ifdef RV_STBUF_FWD_EN
  logic [PTR_W-1:0] fwd_idx;
  logic             unused_addr_m_lo;

  assign unused_addr_m_lo = ^lsu_addr_m[1:0];

  // Forwarding lookup. Entries are walked from oldest (rd_ptr) to newest, and
  // each hit overwrites its lane, so the newest matching store wins per byte.
  // An entry being acked this cycle is still valid here and still forwards.
  always_comb begin
    stbuf_fwdbyteen_m = '0;
    stbuf_fwddata_m   = '0;
    fwd_idx           = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx][ADDR_W-1:2] == lsu_addr_m[ADDR_W-1:2])) begin
        for (int i = 0; i < 4; i++) begin
          if (byteen_q[fwd_idx][i]) begin
            stbuf_fwdbyteen_m[i]     = 1'b1;
            stbuf_fwddata_m[8*i +: 8] = data_q[fwd_idx][8*i +: 8];
          end
        end
      end
    end
  end
`else
  logic unused_addr_m;

  // Forwarding disabled: the load address has no consumer.
  assign unused_addr_m     = ^lsu_addr_m;
  assign stbuf_fwdbyteen_m = '0;
  assign stbuf_fwddata_m   = '0;
`endif

endmodule

// File: tb/tb_el2_lsu_stbuf_q.sv
// ---------------------------------------------------------------------------
// tb_el2_lsu_stbuf_q
//
// Self-checking bench for el2_lsu_stbuf_q (DEPTH=4, ADDR_W=16). A queue-based
// model tracks the store buffer contents; a compare process checks every DUT
// output against it on each falling clock edge. Directed sections pin the
// model with hand-computed literals, then a randomized section runs.
// Set RV_STBUF_FWD_EN to exercise forwarding; otherwise forwarding is
// expected to be zero.
// ---------------------------------------------------------------------------
module tb_el2_lsu_stbuf_q;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 16;

  logic        clk;
  logic        c1_clk;
  logic        rst_l;
  logic        halt;
  logic        reqvld_r;
  logic [15:0] addr_r;
  logic [31:0] data_r;
  logic [3:0]  byteen_r;
  logic        ack;
  logic [15:0] addr_m;

  logic        reqvld_any;
  logic [15:0] addr_any;
  logic [31:0] data_any;
  logic [3:0]  byteen_any;
  logic        empty_any;
  logic        full_any;
  logic [2:0]  numvld_any;
  logic        overflow;
  logic [3:0]  fwdbyteen;
  logic [31:0] fwddata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  logic m_ovf;
  logic m_full;
  logic m_ack;

  el2_lsu_stbuf_q #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .rst_l               (rst_l),
    .lsu_stbuf_c1_clk    (c1_clk),
    .dec_tlu_force_halt  (halt),
    .ldst_stbuf_reqvld_r (reqvld_r),
    .lsu_addr_r          (addr_r),
    .store_data_r        (data_r),
    .lsu_byteen_r        (byteen_r),
    .stbuf_ack_any       (ack),
    .lsu_addr_m          (addr_m),
    .stbuf_reqvld_any    (reqvld_any),
    .stbuf_addr_any      (addr_any),
    .stbuf_data_any      (data_any),
    .stbuf_byteen_any    (byteen_any),
    .lsu_stbuf_empty_any (empty_any),
    .lsu_stbuf_full_any  (full_any),
    .stbuf_numvld_any    (numvld_any),
    .stbuf_overflow      (overflow),
    .stbuf_fwdbyteen_m   (fwdbyteen),
    .stbuf_fwddata_m     (fwddata)
  );

  // Both clocks toggle in one process so their edges land together; the
  // gated clock's enable is held high throughout.
  initial begin
    clk    = 1'b0;
    c1_clk = 1'b0;
    forever begin
      #5;
      clk    = ~clk;
      c1_clk = ~c1_clk;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [15:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic ak, input logic hl,
                               input logic [15:0] am);
    @(posedge clk);
    #1;
    reqvld_r = rv;
    addr_r   = a;
    data_r   = d;
    byteen_r = be;
    ack      = ak;
    halt     = hl;
    addr_m   = am;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic store(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    applyStimulus(1'b1, a, d, be, 1'b0, 1'b0, 16'h0);
  endtask

  // Expected forwarding for one lane set: scan the queue oldest to newest,
  // last match wins. Returns {byteen, data}.
  function automatic logic [35:0] modelFwd(input logic [15:0] am);
    logic [3:0]  fb;
    logic [31:0] fd;
    fb = '0;
    fd = '0;
`ifdef RV_STBUF_FWD_EN
    foreach (q[j]) begin
      if (q[j].addr[15:2] == am[15:2]) begin
        for (int i = 0; i < 4; i++) begin
          if (q[j].be[i]) begin
            fb[i]        = 1'b1;
            fd[8*i +: 8] = q[j].data[8*i +: 8];
          end
        end
      end
    end
`endif
    return {fb, fd};
  endfunction

  // Reference model: a plain FIFO of committed stores, updated on each clk
  // rising edge from the inputs the bench is driving.
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      m_full = (q.size() == DEPTH);
      m_ack  = ack && (q.size() != 0);
      if (halt) begin
        q.delete();
        m_ovf = 1'b0;
      end else begin
        m_ovf = reqvld_r && m_full && !ack;
        if (m_ack) void'(q.pop_front());
        if (reqvld_r && (!m_full || ack)) q.push_back('{addr: addr_r, data: data_r, be: byteen_r});
      end
    end
  end

  // Compare process: every falling edge out of reset, all outputs against
  // the model. Head payload is only meaningful when the queue holds data.
  always @(negedge clk) begin
    if (rst_l) begin
      logic [35:0] ef;
      ef = modelFwd(addr_m);
      checkOutput("reqvld",   32'(reqvld_any), 32'(q.size() != 0));
      checkOutput("empty",    32'(empty_any),  32'(q.size() == 0));
      checkOutput("full",     32'(full_any),   32'(q.size() == DEPTH));
      checkOutput("numvld",   32'(numvld_any), 32'(q.size()));
      checkOutput("overflow", 32'(overflow),   32'(m_ovf));
      checkOutput("fwdbyteen", 32'(fwdbyteen), 32'(ef[35:32]));
      checkOutput("fwddata",  fwddata,         ef[31:0]);
      if (q.size() != 0) begin
        checkOutput("head_addr",   32'(addr_any),   32'(q[0].addr));
        checkOutput("head_data",   data_any,        q[0].data);
        checkOutput("head_byteen", 32'(byteen_any), 32'(q[0].be));
      end
    end
  end

  function automatic logic [15:0] randAddr();
    logic [15:0] a;
    a = 16'h0100 + 16'($urandom_range(0, 3) * 4);
    if ($urandom_range(0, 1) == 1) a = a + 16'h0100;
    return a;
  endfunction

  initial begin
    logic [3:0]  exp_fb;
    logic [31:0] exp_fd;
    logic [15:0] ra;
    rst_l    = 1'b0;
    halt     = 1'b0;
    reqvld_r = 1'b0;
    addr_r   = '0;
    data_r   = '0;
    byteen_r = '0;
    ack      = 1'b0;
    addr_m   = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_reqvld",   32'(reqvld_any), 32'd0);
    checkOutput("rst_empty",    32'(empty_any),  32'd1);
    checkOutput("rst_full",     32'(full_any),   32'd0);
    checkOutput("rst_numvld",   32'(numvld_any), 32'd0);
    checkOutput("rst_overflow", 32'(overflow),   32'd0);
    checkOutput("rst_fwd",      32'(fwdbyteen) | fwddata, 32'd0);
    @(posedge clk);
    #1 rst_l = 1'b1;

    // Single store, one-cycle latency to reqvld, then drain
    store(16'h0104, 32'hAABBCCDD, 4'hF);
    idle();
    @(negedge clk);
    checkOutput("one_reqvld", 32'(reqvld_any), 32'd1);
    checkOutput("one_addr",   32'(addr_any),   32'h0104);
    checkOutput("one_empty",  32'(empty_any),  32'd0);
    checkOutput("one_numvld", 32'(numvld_any), 32'd1);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 1'b0, 16'h0);
    idle();
    @(negedge clk);
    checkOutput("one_drained_empty", 32'(empty_any), 32'd1);

    // Fill, overflow, FIFO drain
    for (int k = 1; k <= 4; k++) store(16'h0100 + 16'(k * 4), 32'h1000 + 32'(k), 4'hF);
    idle();
    @(negedge clk);
    checkOutput("fill_full",   32'(full_any),   32'd1);
    checkOutput("fill_numvld", 32'(numvld_any), 32'd4);
    store(16'h0300, 32'hDEAD0005, 4'hF);
    idle();
    @(negedge clk);
    checkOutput("ovf_pulse",  32'(overflow),   32'd1);
    checkOutput("ovf_numvld", 32'(numvld_any), 32'd4);
    idle();
    @(negedge clk);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("fifo_order", data_any, 32'h1000 + 32'(k));
      applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 1'b0, 16'h0);
      idle();
    end

    // Full with store+ack together, six times to wrap the pointers
    for (int k = 1; k <= 4; k++) store(16'h0100, 32'h3000 + 32'(k), 4'hF);
    for (int j = 1; j <= 6; j++) applyStimulus(1'b1, 16'h0108, 32'h4000 + 32'(j), 4'h3, 1'b1, 1'b0, 16'h0);
    idle();
    @(negedge clk);
    checkOutput("swap_numvld", 32'(numvld_any), 32'd4);
    checkOutput("swap_ovf",    32'(overflow),   32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("swap_order", data_any, 32'h4002 + 32'(k));
      applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 1'b0, 16'h0);
      idle();
    end

    // Force halt with three queued and a same-cycle store
    for (int k = 1; k <= 3; k++) store(16'h0110, 32'h5000 + 32'(k), 4'hF);
    applyStimulus(1'b1, 16'h0114, 32'h55555555, 4'hF, 1'b0, 1'b1, 16'h0);
    idle();
    @(negedge clk);
    checkOutput("halt_empty",  32'(empty_any),  32'd1);
    checkOutput("halt_numvld", 32'(numvld_any), 32'd0);
    checkOutput("halt_reqvld", 32'(reqvld_any), 32'd0);
    checkOutput("halt_ovf",    32'(overflow),   32'd0);

    // Forwarding: newest entry wins per lane
    store(16'h0200, 32'h11223344, 4'hF);
    store(16'h0200, 32'h55667788, 4'h3);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0202);
    @(negedge clk);
`ifdef RV_STBUF_FWD_EN
    exp_fb = 4'hF;
    exp_fd = 32'h11227788;
`else
    exp_fb = 4'h0;
    exp_fd = 32'h0;
`endif
    checkOutput("fwd_byteen", 32'(fwdbyteen), 32'(exp_fb));
    checkOutput("fwd_data",   fwddata,        exp_fd);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0);
    idle();

    // Async reset asserted mid-cycle with two entries queued
    store(16'h0120, 32'h6001, 4'hF);
    store(16'h0124, 32'h6002, 4'hF);
    idle();
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    checkOutput("arst_reqvld", 32'(reqvld_any), 32'd0);
    checkOutput("arst_empty",  32'(empty_any),  32'd1);
    checkOutput("arst_numvld", 32'(numvld_any), 32'd0);
    checkOutput("arst_full",   32'(full_any),   32'd0);
    @(posedge clk);
    #1 rst_l = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ra = randAddr();
      applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom(), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 49) == 0),
                    ra | 16'($urandom_range(0, 3)));
    end
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/el2_lsu_stbuf_q.md
Name: el2_lsu_stbuf_q

Overview:
Small circular store queue between LSU r-stage commit and DCCM write port.
- Accepts committed stores (ldst_stbuf_reqvld_r) and drains them oldest-first to the DCCM.
- Produces stbuf_reqvld_any and lsu_stbuf_empty_any, which drive the LSU clock-enable logic.
- All entry storage is clocked by the gated lsu_stbuf_c1_clk; pointers, count and valids are clocked by clk.

Parameters:
DEPTH, 4, number of entries; power of 2, minimum 2
ADDR_W, 16, DCCM byte-address width
PTR_W, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  in  1  core clock (ACTIVE_L2CLK domain)
rst_l  in  1  asynchronous reset, active-low
lsu_stbuf_c1_clk  in  1  gated clock for entry addr/data/byteen storage
dec_tlu_force_halt  in  1  discard all queued entries
ldst_stbuf_reqvld_r  in  1  committed store allocate request
lsu_addr_r  in  ADDR_W  store byte address, word-aligned in [ADDR_W-1:2]
store_data_r  in  32  store data, byte lanes aligned
lsu_byteen_r  in  4  store byte enables
stbuf_ack_any  in  1  DCCM accepted head entry this cycle
lsu_addr_m  in  ADDR_W  load address for forwarding lookup
stbuf_reqvld_any  out  1  head entry valid, drain requested
stbuf_addr_any  out  ADDR_W  head address
stbuf_data_any  out  32  head data
stbuf_byteen_any  out  4  head byte enables
lsu_stbuf_empty_any  out  1  no valid entries
lsu_stbuf_full_any  out  1  count == DEPTH
stbuf_numvld_any  out  PTR_W+1  valid-entry count
stbuf_overflow  out  1  one-cycle pulse: allocate dropped
stbuf_fwdbyteen_m  out  4  forwarding byte hits
stbuf_fwddata_m  out  32  forwarding data

Behaviour:
- Reset (async, rst_l=0):
  - wr_ptr, rd_ptr, all valid bits and count cleared.
  - Outputs: stbuf_reqvld_any=0, lsu_stbuf_empty_any=1, full=0, numvld=0, overflow=0, fwd outputs 0.
  - Entry payloads are not reset.
- Allocate condition: accept = ldst_stbuf_reqvld_r & (~full | stbuf_ack_any) & ~dec_tlu_force_halt.
- On accept:
  - entry[wr_ptr] is written with addr/data/byteen on lsu_stbuf_c1_clk.
  - valid[wr_ptr] set on next clk edge; wr_ptr increments and wraps DEPTH-1 -> 0.
- Full and ack in the same cycle: the allocate is accepted; count stays DEPTH and both pointers advance.
- ldst_stbuf_reqvld_r while full and no ack: request dropped; stbuf_overflow=1 for exactly one cycle; no state changes.
- Drain:
  - stbuf_reqvld_any = valid[rd_ptr]; head outputs are combinational from entry[rd_ptr].
  - stbuf_ack_any with reqvld=1: valid[rd_ptr] cleared; rd_ptr increments and wraps.
  - stbuf_ack_any while empty: ignored (assertion in bench).
- Count update per cycle: +1 on accept, -1 on ack, unchanged if both. Range 0..DEPTH, never wraps.
- Status: lsu_stbuf_empty_any = (count==0); lsu_stbuf_full_any = (count==DEPTH). Both are registered-state derived (no comb path from inputs).
- Empty-to-first-request latency: a store accepted at cycle N gives stbuf_reqvld_any=1 at N+1.
- dec_tlu_force_halt=1: next clk edge clears all valids, pointers and count. It overrides same-cycle allocate and ack. overflow is not asserted.
- Reset mid-drain: queue empties immediately; no partial entry survives.
- Clocking contract: the upstream clock enable must be high on any accept cycle. Head outputs are stable while the enable is low.

Optional Feature:
Macro: RV_STBUF_FWD_EN
- Defined:
  - Each valid entry compares addr[ADDR_W-1:2] with lsu_addr_m[ADDR_W-1:2].
  - Per byte lane, the newest matching valid entry with the byteen bit set wins (age relative to rd_ptr, wrap-aware).
  - stbuf_fwdbyteen_m[i] = 1 and stbuf_fwddata_m[8i+7:8i] = that entry's byte.
  - Lanes with no hit drive 0.
  - Purely combinational; entries being acked this cycle still forward.
- Undefined: stbuf_fwdbyteen_m and stbuf_fwddata_m are tied to 0 and no comparators are built.

Test Plan:
- Reset, then one store: addr 0x0104, data 0xAABBCCDD, byteen 0xF at cycle 1 -> cycle 2: reqvld=1, addr_any=0x0104, empty=0, numvld=1. Ack at cycle 3 -> cycle 4: empty=1.
- 4 stores with no ack (DEPTH=4) -> full=1, numvld=4. A 5th store -> overflow pulses 1 cycle, numvld stays 4. Drain order is FIFO 1,2,3,4.
- Full with store and ack in the same cycle -> numvld stays 4, new entry is the last drained. Repeat 6 times to exercise pointer wrap.
- Force halt with 3 entries queued plus a same-cycle store -> next cycle: empty=1, numvld=0, reqvld=0, overflow=0.
- FWD_EN: entry A 0x0200 data 0x11223344 byteen 0xF; then entry B 0x0200 data 0x55667788 byteen 0x3. Load lsu_addr_m=0x0202 -> fwdbyteen=0xF, fwddata=0x11227788.
- Async reset asserted mid-cycle with 2 entries queued -> outputs return to reset values immediately, without waiting for a clk edge.
